// File: rtl/menu_nav_ctrl_if.sv
// Key pulses into, and cursor/configuration state out of, the front-panel menu controller.
interface menu_nav_ctrl_if #(
  parameter int N_MODES  = 3,
  parameter int N_FIELDS = 4,
  parameter int FIELD_W  = 2
);
  localparam int MODE_W = (N_MODES > 1) ? $clog2(N_MODES) : 1;
  localparam int ROW_W  = ($clog2(N_FIELDS + 1) > 0) ? $clog2(N_FIELDS + 1) : 1;

  logic                                  left;
  logic                                  right;
  logic                                  up;
  logic                                  down;
  logic                                  confirm;
  logic                                  quit;
  logic                                  level;
  logic [MODE_W-1:0]                     mode_sel;
  logic [ROW_W-1:0]                      row_sel;
  logic [N_FIELDS*FIELD_W-1:0]           edit_vals;
  logic [N_MODES*N_FIELDS*FIELD_W-1:0]   cfg_out;
  logic                                  apply_strobe;
  logic [MODE_W-1:0]                     apply_mode;
  logic                                  dirty;

  modport master (
    output left, right, up, down, confirm, quit,
    input  level, mode_sel, row_sel, edit_vals, cfg_out, apply_strobe, apply_mode, dirty
  );

  modport slave (
    input  left, right, up, down, confirm, quit,
    output level, mode_sel, row_sel, edit_vals, cfg_out, apply_strobe, apply_mode, dirty
  );
endinterface

// File: rtl/menu_nav_ctrl.sv
// Two-level menu navigation: mode cursor in TOP, row cursor plus shadow edit bank in SUB,
// committing the shadow bank into a per-mode configuration register on apply.
module menu_nav_ctrl #(
  parameter int N_MODES         = 3,
  parameter int N_FIELDS        = 4,
  parameter int FIELD_W         = 2,
  parameter int FIELD_MAX       = 3,
  parameter int RETURN_ON_APPLY = 0
) (
  input  logic           clk_50M,
  input  logic           rst_n,
  menu_nav_ctrl_if.slave bus
);
  localparam int MODE_W = (N_MODES > 1) ? $clog2(N_MODES) : 1;
  localparam int ROW_W  = ($clog2(N_FIELDS + 1) > 0) ? $clog2(N_FIELDS + 1) : 1;

  localparam logic [MODE_W-1:0]  MODE_LAST = MODE_W'(N_MODES - 1);
  localparam logic [ROW_W-1:0]   ROW_APPLY = ROW_W'(N_FIELDS);
  localparam logic [FIELD_W-1:0] FMAX      = FIELD_W'(FIELD_MAX);

  typedef enum logic [1:0] {
    ST_TOP = 2'd0,
    ST_SUB = 2'd1
  } state_t;

  state_t                                         state_reg, state_next;
  logic [MODE_W-1:0]                              mode_reg, mode_next;
  logic [ROW_W-1:0]                               row_reg, row_next;
  logic [N_FIELDS-1:0][FIELD_W-1:0]               edit_reg, edit_next;
  logic [N_MODES-1:0][N_FIELDS-1:0][FIELD_W-1:0]  cfg_reg, cfg_next;
  logic                                           strobe_reg, strobe_next;
  logic [MODE_W-1:0]                              amode_reg, amode_next;
  logic                                           dirty_reg, dirty_next;

  logic key_up, key_down, key_left, key_right;
  logic [N_FIELDS-1:0][FIELD_W-1:0] cur_bank;
  logic [N_FIELDS-1:0][FIELD_W-1:0] field_inc;
  logic [N_FIELDS-1:0][FIELD_W-1:0] field_dec;

  // Opposing keys pressed together cancel each other.
  assign key_up    = bus.up & ~bus.down;
  assign key_down  = bus.down & ~bus.up;
  assign key_left  = bus.left & ~bus.right;
  assign key_right = bus.right & ~bus.left;

  genvar gi;
  generate
    for (gi = 0; gi < N_FIELDS; gi++) begin : g_field
      assign field_inc[gi] = (edit_reg[gi] >= FMAX) ? '0 : edit_reg[gi] + FIELD_W'(1);
      assign field_dec[gi] = (edit_reg[gi] == '0 || edit_reg[gi] > FMAX) ? FMAX
                                                                         : edit_reg[gi] - FIELD_W'(1);
    end
  endgenerate

  always_comb begin
    cur_bank = '0;
    for (int m = 0; m < N_MODES; m++) begin
      if (mode_reg == MODE_W'(m)) cur_bank = cfg_reg[m];
    end
  end

  always_comb begin
    state_next  = state_reg;
    mode_next   = mode_reg;
    row_next    = row_reg;
    edit_next   = edit_reg;
    cfg_next    = cfg_reg;
    strobe_next = 1'b0;
    amode_next  = amode_reg;
    dirty_next  = dirty_reg;
    case (state_reg)
      ST_TOP: begin
        if (bus.confirm) begin
          state_next = ST_SUB;
          row_next   = '0;
          edit_next  = cur_bank;
          dirty_next = 1'b0;
        end else if (key_left) begin
          mode_next = (mode_reg == '0) ? MODE_LAST : mode_reg - MODE_W'(1);
        end else if (key_right) begin
          mode_next = (mode_reg >= MODE_LAST) ? '0 : mode_reg + MODE_W'(1);
        end
      end
      ST_SUB: begin
        if (bus.quit) begin
          // Leaving without apply reverts the shadow bank to the committed one.
          state_next = ST_TOP;
          row_next   = '0;
          edit_next  = cur_bank;
          dirty_next = 1'b0;
        end else if (bus.confirm) begin
          if (row_reg >= ROW_APPLY) begin
            for (int m = 0; m < N_MODES; m++) begin
              if (mode_reg == MODE_W'(m)) cfg_next[m] = edit_reg;
            end
            strobe_next = 1'b1;
            amode_next  = mode_reg;
            dirty_next  = 1'b0;
            if (RETURN_ON_APPLY != 0) begin
              state_next = ST_TOP;
              row_next   = '0;
            end
          end else begin
            row_next = row_reg + ROW_W'(1);
          end
        end else if (key_up) begin
          row_next = (row_reg == '0 || row_reg > ROW_APPLY) ? ROW_APPLY : row_reg - ROW_W'(1);
        end else if (key_down) begin
          row_next = (row_reg >= ROW_APPLY) ? '0 : row_reg + ROW_W'(1);
        end else if (key_left || key_right) begin
          for (int i = 0; i < N_FIELDS; i++) begin
            if (row_reg == ROW_W'(i)) begin
              edit_next[i] = key_right ? field_inc[i] : field_dec[i];
              dirty_next   = 1'b1;
            end
          end
        end
      end
      default: begin
        state_next = ST_TOP;
        row_next   = '0;
        dirty_next = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk_50M or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_TOP;
      mode_reg   <= '0;
      row_reg    <= '0;
      edit_reg   <= '0;
      cfg_reg    <= '0;
      strobe_reg <= 1'b0;
      amode_reg  <= '0;
      dirty_reg  <= 1'b0;
    end else begin
      state_reg  <= state_next;
      mode_reg   <= mode_next;
      row_reg    <= row_next;
      edit_reg   <= edit_next;
      cfg_reg    <= cfg_next;
      strobe_reg <= strobe_next;
      amode_reg  <= amode_next;
      dirty_reg  <= dirty_next;
    end
  end

  assign bus.level        = (state_reg == ST_SUB);
  assign bus.mode_sel     = mode_reg;
  assign bus.row_sel      = row_reg;
  assign bus.edit_vals    = edit_reg;
  assign bus.cfg_out      = cfg_reg;
  assign bus.apply_strobe = strobe_reg;
  assign bus.apply_mode   = amode_reg;
  assign bus.dirty        = dirty_reg;
endmodule

// File: tb/tb_menu_nav_ctrl.sv
// Scoreboard bench for menu_nav_ctrl: a reference model queues the expected output state
// for every key pulse, popped and compared one cycle later.
module tb_menu_nav_ctrl;
  localparam logic [5:0] K_0 = 6'b000000;
  localparam logic [5:0] K_Q = 6'b100000;
  localparam logic [5:0] K_C = 6'b010000;
  localparam logic [5:0] K_U = 6'b001000;
  localparam logic [5:0] K_D = 6'b000100;
  localparam logic [5:0] K_L = 6'b000010;
  localparam logic [5:0] K_R = 6'b000001;

  typedef struct packed {
    logic        level;
    logic [1:0]  mode;
    logic [2:0]  row;
    logic [7:0]  edit;
    logic [23:0] cfg;
    logic        strobe;
    logic [1:0]  amode;
    logic        dirty;
  } snap_t;

  logic clk_50M = 1'b0;
  logic rst_n   = 1'b1;
  int   n_cmp   = 0;
  int   n_err   = 0;
  snap_t exp_q[$];

  int m_sub, m_mode, m_row, m_dirty, m_strobe, m_amode;
  int m_edit[4];
  int m_cfg[3][4];

  always #10 clk_50M = ~clk_50M;

  menu_nav_ctrl_if bus ();
  menu_nav_ctrl_if bus_r ();

  menu_nav_ctrl #(.RETURN_ON_APPLY(0)) dut (
    .clk_50M(clk_50M), .rst_n(rst_n), .bus(bus)
  );
  menu_nav_ctrl #(.RETURN_ON_APPLY(1)) dut_r (
    .clk_50M(clk_50M), .rst_n(rst_n), .bus(bus_r)
  );

  function automatic snap_t model_snap();
    snap_t s;
    logic [7:0]  e;
    logic [23:0] c;
    e = '0;
    c = '0;
    for (int i = 0; i < 4; i++) e[i*2 +: 2] = 2'(m_edit[i]);
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < 4; i++) c[(m*4+i)*2 +: 2] = 2'(m_cfg[m][i]);
    s.level  = 1'(m_sub);
    s.mode   = 2'(m_mode);
    s.row    = 3'(m_row);
    s.edit   = e;
    s.cfg    = c;
    s.strobe = 1'(m_strobe);
    s.amode  = 2'(m_amode);
    s.dirty  = 1'(m_dirty);
    return s;
  endfunction

  function automatic snap_t observe();
    snap_t s;
    s.level  = bus.level;
    s.mode   = bus.mode_sel;
    s.row    = bus.row_sel;
    s.edit   = bus.edit_vals;
    s.cfg    = bus.cfg_out;
    s.strobe = bus.apply_strobe;
    s.amode  = bus.apply_mode;
    s.dirty  = bus.dirty;
    return s;
  endfunction

  task automatic model_reset();
    m_sub = 0; m_mode = 0; m_row = 0; m_dirty = 0; m_strobe = 0; m_amode = 0;
    for (int i = 0; i < 4; i++) m_edit[i] = 0;
    for (int m = 0; m < 3; m++)
      for (int i = 0; i < 4; i++) m_cfg[m][i] = 0;
  endtask

  // Reference behaviour: quit > confirm > up/down > left/right, opposing pairs cancel.
  task automatic model_step(input logic [5:0] k);
    int dv, dh;
    dv = (k[3] && !k[2]) ? -1 : ((k[2] && !k[3]) ? 1 : 0);
    dh = (k[0] && !k[1]) ? 1 : ((k[1] && !k[0]) ? -1 : 0);
    m_strobe = 0;
    if (m_sub == 0) begin
      if (k[4]) begin
        m_sub = 1; m_row = 0; m_dirty = 0;
        for (int i = 0; i < 4; i++) m_edit[i] = m_cfg[m_mode][i];
      end else if (dh != 0) begin
        m_mode = (m_mode + dh + 3) % 3;
      end
    end else if (k[5]) begin
      m_sub = 0; m_row = 0; m_dirty = 0;
      for (int i = 0; i < 4; i++) m_edit[i] = m_cfg[m_mode][i];
    end else if (k[4]) begin
      if (m_row == 4) begin
        for (int i = 0; i < 4; i++) m_cfg[m_mode][i] = m_edit[i];
        m_strobe = 1; m_amode = m_mode; m_dirty = 0;
      end else begin
        m_row = m_row + 1;
      end
    end else if (dv != 0) begin
      m_row = (m_row + dv + 5) % 5;
    end else if (dh != 0 && m_row < 4) begin
      m_edit[m_row] = (m_edit[m_row] + dh + 4) % 4;
      m_dirty = 1;
    end
    exp_q.push_back(model_snap());
  endtask

  task automatic press(input logic [5:0] k);
    @(negedge clk_50M);
    {bus.quit, bus.confirm, bus.up, bus.down, bus.left, bus.right} = k;
    model_step(k);
    @(posedge clk_50M);
    #1;
    {bus.quit, bus.confirm, bus.up, bus.down, bus.left, bus.right} = 6'b0;
  endtask

  task automatic press_r(input logic [5:0] k);
    @(negedge clk_50M);
    {bus_r.quit, bus_r.confirm, bus_r.up, bus_r.down, bus_r.left, bus_r.right} = k;
    @(posedge clk_50M);
    #1;
    {bus_r.quit, bus_r.confirm, bus_r.up, bus_r.down, bus_r.left, bus_r.right} = 6'b0;
  endtask

  task automatic test_reset();
    snap_t got, want;
    rst_n = 1'b1;
    #2 rst_n = 1'b0;
    model_reset();
    repeat (2) @(posedge clk_50M);
    #1;
    got = observe(); want = model_snap();
    n_cmp++;
    if (got !== want) begin
      n_err++; $display("FAIL reset_state got %h want %h", got, want);
    end
    n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL reset_zero got %h want 0", got);
    end
    @(negedge clk_50M);
    rst_n = 1'b1;
    $display("reset released");
  endtask

  task automatic test_mode_nav();
    logic [5:0] keys [6] = '{K_R, K_R, K_R, K_R, K_L, K_L};
    int         modes[6] = '{1, 2, 0, 1, 0, 2};
    snap_t got, want;
    for (int i = 0; i < 6; i++) begin
      press(keys[i]);
      got = observe(); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL mode_nav_sb[%0d] got %h want %h", i, got, want);
      end
      n_cmp++;
      if (bus.mode_sel !== 2'(modes[i]) || bus.level !== 1'b0) begin
        n_err++;
        $display("FAIL mode_nav[%0d] got mode %0d level %b want mode %0d level 0",
                 i, bus.mode_sel, bus.level, modes[i]);
      end
      $display("mode_nav key=%b mode_sel=%0d level=%b", keys[i], bus.mode_sel, bus.level);
    end
  endtask

  task automatic test_field_edit();
    int f0[5] = '{1, 2, 3, 0, 1};
    snap_t got, want;
    press(K_R);
    press(K_C);
    for (int i = 0; i < 2; i++) begin
      got = observe(); want = exp_q.pop_front();
      if (i == 1) begin
        n_cmp++;
        if (got !== want) begin
          n_err++; $display("FAIL enter_sb got %h want %h", got, want);
        end
      end
    end
    n_cmp++;
    if (bus.level !== 1'b1 || bus.row_sel !== 3'd0 || bus.edit_vals !== 8'h00 || bus.mode_sel !== 2'd0) begin
      n_err++;
      $display("FAIL enter_sub got level %b row %0d edit %h mode %0d want 1 0 00 0",
               bus.level, bus.row_sel, bus.edit_vals, bus.mode_sel);
    end
    $display("enter level=%b row_sel=%0d edit_vals=%h", bus.level, bus.row_sel, bus.edit_vals);
    for (int i = 0; i < 5; i++) begin
      press(K_R);
      got = observe(); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL field_edit_sb[%0d] got %h want %h", i, got, want);
      end
      n_cmp++;
      if (bus.edit_vals[1:0] !== 2'(f0[i]) || bus.dirty !== 1'b1) begin
        n_err++;
        $display("FAIL field_edit[%0d] got field0 %0d dirty %b want %0d dirty 1",
                 i, bus.edit_vals[1:0], bus.dirty, f0[i]);
      end
      $display("field_edit field0=%0d dirty=%b", bus.edit_vals[1:0], bus.dirty);
    end
  endtask

  task automatic test_apply();
    logic [5:0] keys [6] = '{K_D, K_D, K_L, K_D, K_D, K_C};
    snap_t got, want;
    for (int i = 0; i < 6; i++) begin
      press(keys[i]);
      got = observe(); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL apply_sb[%0d] got %h want %h", i, got, want);
      end
      $display("apply key=%b row_sel=%0d edit_vals=%h strobe=%b", keys[i], bus.row_sel,
               bus.edit_vals, bus.apply_strobe);
    end
    n_cmp++;
    if (bus.apply_strobe !== 1'b1 || bus.apply_mode !== 2'd0 || bus.cfg_out[5:4] !== 2'd3 ||
        bus.cfg_out[7:0] !== 8'h31 || bus.dirty !== 1'b0 || bus.row_sel !== 3'd4 || bus.level !== 1'b1) begin
      n_err++;
      $display("FAIL apply_commit got strobe %b mode %0d bank0 %h dirty %b row %0d level %b want 1 0 31 0 4 1",
               bus.apply_strobe, bus.apply_mode, bus.cfg_out[7:0], bus.dirty, bus.row_sel, bus.level);
    end
    press(K_0);
    got = observe(); want = exp_q.pop_front();
    n_cmp++;
    if (got !== want || bus.apply_strobe !== 1'b0) begin
      n_err++; $display("FAIL apply_strobe_width got %h want %h", got, want);
    end
  endtask

  task automatic test_back_to_back();
    snap_t got, want;
    for (int i = 0; i < 2; i++) begin
      press(K_C);
      got = observe(); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want || bus.apply_strobe !== 1'b1) begin
        n_err++; $display("FAIL back_to_back[%0d] got %h want %h", i, got, want);
      end
      $display("back_to_back strobe=%b apply_mode=%0d", bus.apply_strobe, bus.apply_mode);
    end
    press(K_0);
    got = observe(); want = exp_q.pop_front();
    n_cmp++;
    if (got !== want || bus.apply_strobe !== 1'b0) begin
      n_err++; $display("FAIL back_to_back_end got %h want %h", got, want);
    end
  endtask

  task automatic test_quit_discard();
    logic [5:0] keys [7] = '{K_U, K_U, K_U, K_R, K_R, K_Q, K_C};
    snap_t got, want;
    for (int i = 0; i < 7; i++) begin
      press(keys[i]);
      got = observe(); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL quit_sb[%0d] got %h want %h", i, got, want);
      end
      $display("quit_discard key=%b level=%b edit_vals=%h cfg_out=%h", keys[i], bus.level,
               bus.edit_vals, bus.cfg_out);
      if (i == 4) begin
        n_cmp++;
        if (bus.edit_vals !== 8'h39) begin
          n_err++; $display("FAIL quit_edit got %h want 39", bus.edit_vals);
        end
      end
      if (i == 5) begin
        n_cmp++;
        if (bus.level !== 1'b0 || bus.cfg_out !== 24'h000031) begin
          n_err++; $display("FAIL quit_exit got level %b cfg %h want 0 000031", bus.level, bus.cfg_out);
        end
      end
    end
    n_cmp++;
    if (bus.edit_vals !== 8'h31 || bus.level !== 1'b1) begin
      n_err++; $display("FAIL reenter_bank got %h want 31", bus.edit_vals);
    end
  endtask

  task automatic test_key_priority();
    logic [5:0] keys [4] = '{K_U | K_D, K_C | K_U, K_L | K_R, K_Q | K_L};
    logic [2:0] rows [4] = '{3'd0, 3'd1, 3'd1, 3'd0};
    logic       lvls [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    snap_t got, want;
    for (int i = 0; i < 4; i++) begin
      press(keys[i]);
      got = observe(); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL priority_sb[%0d] got %h want %h", i, got, want);
      end
      n_cmp++;
      if (bus.row_sel !== rows[i] || bus.level !== lvls[i] || bus.mode_sel !== 2'd0 ||
          bus.edit_vals !== 8'h31) begin
        n_err++;
        $display("FAIL priority[%0d] got row %0d level %b mode %0d edit %h want %0d %b 0 31",
                 i, bus.row_sel, bus.level, bus.mode_sel, bus.edit_vals, rows[i], lvls[i]);
      end
      $display("priority key=%b row_sel=%0d level=%b", keys[i], bus.row_sel, bus.level);
    end
  endtask

  task automatic test_random();
    logic [5:0] k;
    snap_t got, want;
    int errs_before;
    errs_before = n_err;
    for (int i = 0; i < 400; i++) begin
      for (int b = 0; b < 6; b++) k[b] = ($urandom_range(0, 4) == 0);
      if (k[5] && $urandom_range(0, 3) != 0) k[5] = 1'b0;
      press(k);
      got = observe(); want = exp_q.pop_front();
      n_cmp++;
      if (got !== want) begin
        n_err++; $display("FAIL random[%0d] key %b got %h want %h", i, k, got, want);
      end
      $display("random key=%b state=%h", k, got);
    end
    $display("random done, %0d new mismatches", n_err - errs_before);
  endtask

  task automatic test_return_on_apply();
    logic [5:0] keys [6] = '{K_R, K_R, K_C, K_R, K_U, K_C};
    for (int i = 0; i < 6; i++) begin
      press_r(keys[i]);
      $display("return_on_apply key=%b level=%b mode=%0d row=%0d cfg_out=%h strobe=%b", keys[i],
               bus_r.level, bus_r.mode_sel, bus_r.row_sel, bus_r.cfg_out, bus_r.apply_strobe);
      if (i == 4) begin
        n_cmp++;
        if (bus_r.level !== 1'b1 || bus_r.row_sel !== 3'd4 || bus_r.edit_vals !== 8'h01 || bus_r.dirty !== 1'b1) begin
          n_err++;
          $display("FAIL roa_pre got level %b row %0d edit %h dirty %b want 1 4 01 1",
                   bus_r.level, bus_r.row_sel, bus_r.edit_vals, bus_r.dirty);
        end
      end
    end
    n_cmp++;
    if (bus_r.level !== 1'b0 || bus_r.row_sel !== 3'd0 || bus_r.apply_strobe !== 1'b1 ||
        bus_r.apply_mode !== 2'd2 || bus_r.cfg_out !== 24'h010000 || bus_r.mode_sel !== 2'd2) begin
      n_err++;
      $display("FAIL roa_apply got level %b row %0d strobe %b amode %0d cfg %h want 0 0 1 2 010000",
               bus_r.level, bus_r.row_sel, bus_r.apply_strobe, bus_r.apply_mode, bus_r.cfg_out);
    end
    press_r(K_0);
    n_cmp++;
    if (bus_r.apply_strobe !== 1'b0 || bus_r.level !== 1'b0) begin
      n_err++; $display("FAIL roa_after got strobe %b level %b want 0 0", bus_r.apply_strobe, bus_r.level);
    end
  endtask

  task automatic test_async_reset();
    snap_t got, want;
    press(K_C);
    void'(exp_q.pop_front());
    press(K_R);
    void'(exp_q.pop_front());
    @(posedge clk_50M);
    #5 rst_n = 1'b0;
    #1;
    model_reset();
    got = observe();
    n_cmp++;
    if (got !== '0) begin
      n_err++; $display("FAIL async_reset got %h want 0", got);
    end
    n_cmp++;
    if ({bus_r.level, bus_r.mode_sel, bus_r.row_sel, bus_r.edit_vals, bus_r.cfg_out,
         bus_r.apply_strobe, bus_r.apply_mode, bus_r.dirty} !== 42'd0) begin
      n_err++; $display("FAIL async_reset_r got cfg %h level %b want 0", bus_r.cfg_out, bus_r.level);
    end
    $display("async_reset state=%h", got);
    @(negedge clk_50M);
    rst_n = 1'b1;
    press(K_R);
    got = observe(); want = exp_q.pop_front();
    n_cmp++;
    if (got !== want || bus.mode_sel !== 2'd1) begin
      n_err++; $display("FAIL post_reset got %h want %h", got, want);
    end
  endtask

  initial begin
    {bus.quit, bus.confirm, bus.up, bus.down, bus.left, bus.right} = 6'b0;
    {bus_r.quit, bus_r.confirm, bus_r.up, bus_r.down, bus_r.left, bus_r.right} = 6'b0;
    test_reset();
    test_mode_nav();
    test_field_edit();
    test_apply();
    test_back_to_back();
    test_quit_discard();
    test_key_priority();
    test_random();
    test_return_on_apply();
    test_async_reset();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog expired before the test sequence completed");
    $fatal(1, "watchdog");
  end
endmodule

// File: doc/menu_nav_ctrl.md
# menu_nav_ctrl

Parametrised two-level menu navigation and configuration-commit controller for the front-panel UI. It consumes single-cycle debounced key-release pulses and maintains a mode cursor, a row cursor and a shadow edit bank per mode. On explicit apply, it commits the shadow bank into a per-mode committed configuration register. It sits between the key debouncers and the signal-generator, HDMI overlay and other mode engines, and replaces hard-coded menu counters with a generic, resettable, glitch-free controller.

## Interface
- N_MODES, 3: number of top-level menu entries, at least 2.
- N_FIELDS, 4: editable fields per mode, at least 1. Row index N_FIELDS is the "apply" row.
- FIELD_W, 2: bits per field value.
- FIELD_MAX, 3: largest legal field value, at most 2^FIELD_W−1.
- RETURN_ON_APPLY, 0: 0 means stay in SUB after apply; 1 means return to TOP after apply.
- Derived widths: MODE_W = max(1, clog2(N_MODES)); ROW_W = max(1, clog2(N_FIELDS+1)).

Ports:
- clk_50M  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- left, right, up, down, confirm, quit  in  1 each  single-cycle key pulses.
- level  out  1  0 = TOP, 1 = SUB.
- mode_sel  out  MODE_W  mode cursor.
- row_sel  out  ROW_W  row cursor; only meaningful in SUB.
- edit_vals  out  N_FIELDS*FIELD_W  shadow bank; field i occupies bits [i*FIELD_W +: FIELD_W].
- cfg_out  out  N_MODES*N_FIELDS*FIELD_W  committed banks; mode m field i occupies bits [(m*N_FIELDS+i)*FIELD_W +: FIELD_W].
- apply_strobe  out  1  one-cycle pulse when a bank is committed.
- apply_mode  out  MODE_W  index of the bank last committed.
- dirty  out  1  the shadow bank has been edited since entry or since the last apply.

## Operation
- Reset: all outputs and state are zero. The FSM enters TOP.
- Same-cycle key priority: quit > confirm > up/down > left/right.
  - up and down together: neither acts.
  - left and right together: neither acts.
  - Only the single highest-priority key acts in a cycle.
- TOP state:
  - left: mode_sel decrements; 0 wraps to N_MODES−1.
  - right: mode_sel increments; N_MODES−1 wraps to 0.
  - confirm: go to SUB. Set row_sel=0, edit_vals←cfg bank[mode_sel], dirty=0.
  - quit, up, down: ignored.
- SUB state:
  - up: row_sel decrements; 0 wraps to N_FIELDS.
  - down: row_sel increments; N_FIELDS wraps to 0.
  - left/right on row i < N_FIELDS: field i decrements/increments within 0..FIELD_MAX with wrap-around, and dirty is set to 1. Values above FIELD_MAX are never produced.
  - left/right on the apply row: ignored.
  - confirm on row i < N_FIELDS: row_sel moves to i+1 (cursor advance only; nothing is committed).
  - confirm on the apply row:
    - cfg bank[mode_sel]←edit_vals; apply_strobe=1; apply_mode=mode_sel; dirty=0.
    - If RETURN_ON_APPLY=1, go to TOP with row_sel=0; otherwise stay on the apply row.
    - Applying with dirty=0 still commits and still strobes.
  - quit: go to TOP. Discard shadow edits, set row_sel=0, dirty=0. mode_sel and cfg_out are unchanged.
- Other banks of cfg_out change only on an apply for that mode.
- Illegal or unreachable FSM state encodings recover to TOP on the next clock.

## Timing
- Every output is a register. A key pulse sampled at edge N takes effect in outputs after edge N (latency 1 cycle). No combinational paths run from inputs to outputs.
- apply_strobe is high for exactly one cycle per apply. Back-to-back applies on consecutive cycles give consecutive strobes.
- edit_vals reflects the loaded bank on the cycle after the entering confirm.
- Asserting rst_n low mid-edit or mid-apply clears everything asynchronously, including cfg_out. Release is synchronous to clk_50M by the upstream reset synchroniser.
- Held inputs are not expected, because inputs are pulses. A level held high acts on every cycle.

## Test plan
All scenarios use the default parameters.
- Reset then right ×4 → mode_sel 0→1→2→0→1. Then left ×2 → 0→2. level stays 0 throughout.
- On mode 0: confirm → level=1, row_sel=0, edit_vals=0. Then right ×5 → field0 reads 1,2,3,0,1 and dirty=1.
- Edit field2 to 3, down ×4 to the apply row (row_sel=4), then confirm → apply_strobe=1 for one cycle, apply_mode=0, cfg_out bits[5:4]=3, dirty=0.
- Edit field1 to 2, then quit → level=0 and cfg_out is unchanged. Re-enter → edit_vals equals the committed bank (field1 is not 2).
- Pulse quit and left together in SUB → exit to TOP with mode_sel unchanged. Pulse up and down together → row_sel unchanged.
- With RETURN_ON_APPLY=1, apply on mode 2 → level=0 next cycle and bank 2 is updated. Assert rst_n low mid-edit → every output reads 0 immediately.
